// File: rtl/lsu_req_ctrl.sv
// lsu_req_ctrl: single-outstanding load/store bus request controller.
// Latches the access at issue, drives the bus from registers, and returns the raw read word.
module lsu_req_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_ls_ena,
  input  logic [3:0]  ex_ls_sel,
  input  logic [31:0] ex_ls_addr,
  input  logic [31:0] ex_rt_data,
  input  logic        ex_has_exception,
  input  logic        flush,
  output logic        ls_stall,
  output logic [31:0] ls_rdata,
  output logic        ls_rdata_valid,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);
  localparam logic [3:0] LS_LB = 4'd0, LS_LBU = 4'd1, LS_LH = 4'd2, LS_LHU = 4'd3, LS_LW = 4'd4;
  localparam logic [3:0] LS_LWL = 4'd5, LS_LWR = 4'd6;
  localparam logic [3:0] LS_SB = 4'd8, LS_SH = 4'd9, LS_SW = 4'd10, LS_SWL = 4'd11, LS_SWR = 4'd12;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, CANCEL} state_t;
  state_t      r_state;
  logic        r_wr, r_valid;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        w_start, w_done, w_unal;
  logic [1:0]  w_a, w_size;
  logic [3:0]  w_wstrb;
  logic [31:0] w_addr, w_wdata;
  always_comb begin
    w_a = ex_ls_addr[1:0];
    w_unal = ex_ls_sel inside {LS_LWL, LS_LWR, LS_SWL, LS_SWR};
    w_size = w_unal ? 2'd2 :
             ex_ls_sel inside {LS_LB, LS_LBU, LS_SB} ? 2'd0 :
             ex_ls_sel inside {LS_LH, LS_LHU, LS_SH} ? 2'd1 : 2'd2;
    w_addr = w_unal ? {ex_ls_addr[31:2], 2'b00} : ex_ls_addr;
    w_wstrb = ex_ls_sel == LS_SB  ? 4'b0001 << w_a :
              ex_ls_sel == LS_SH  ? (w_a[1] ? 4'b1100 : 4'b0011) :
              ex_ls_sel == LS_SW  ? 4'b1111 :
              ex_ls_sel == LS_SWL ? 4'b1111 >> ~w_a :
              ex_ls_sel == LS_SWR ? 4'b1111 << w_a : 4'b0000;
    w_wdata = ex_ls_sel == LS_SB  ? {4{ex_rt_data[7:0]}} :
              ex_ls_sel == LS_SH  ? {2{ex_rt_data[15:0]}} :
              ex_ls_sel == LS_SWL ? ex_rt_data >> {~w_a, 3'b000} :
              ex_ls_sel == LS_SWR ? ex_rt_data << {w_a, 3'b000} : ex_rt_data;
    w_start = r_state == IDLE && ex_ls_ena && !ex_has_exception && !flush && !rst;
    // a flushed request whose response arrives with acceptance is dropped, not completed
    w_done = (r_state == REQ && data_addr_ok && data_data_ok && !flush) ||
             (r_state == WAIT && data_data_ok);
  end
  assign ls_stall = w_start || (r_state == REQ && !(data_addr_ok && data_data_ok)) ||
                    (r_state == WAIT && !data_data_ok) || (r_state == CANCEL && ex_ls_ena);
  assign ls_rdata = r_rdata;
  assign ls_rdata_valid = r_valid;
  assign data_req = r_state == REQ;
  assign data_wr = r_wr;
  assign data_size = r_size;
  assign data_addr = r_addr;
  assign data_wstrb = r_wstrb;
  assign data_wdata = r_wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_wr <= 1'b0;
      r_valid <= 1'b0;
      r_size <= 2'd0;
      r_wstrb <= 4'd0;
      r_addr <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      r_valid <= w_done;
      if (w_done && !r_wr) r_rdata <= data_rdata;
      case (r_state)
        IDLE: if (w_start) begin
          r_state <= REQ;
          r_wr <= ex_ls_sel[3];
          r_size <= w_size;
          r_addr <= w_addr;
          r_wstrb <= w_wstrb;
          r_wdata <= w_wdata;
        end
        REQ: if (data_addr_ok) r_state <= data_data_ok ? IDLE : flush ? CANCEL : WAIT;
             else if (flush) r_state <= IDLE;
        WAIT: if (data_data_ok) r_state <= IDLE;
              else if (flush) r_state <= CANCEL;
        CANCEL: if (data_data_ok) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_req_ctrl.sv
// tb_lsu_req_ctrl: directed and random checks of lsu_req_ctrl against a transaction-level model.
module tb_lsu_req_ctrl;
  localparam logic [3:0] LB = 4'd0, LBU = 4'd1, LH = 4'd2, LHU = 4'd3, LW = 4'd4, LWL = 4'd5, LWR = 4'd6;
  localparam logic [3:0] SB = 4'd8, SH = 4'd9, SW = 4'd10, SWL = 4'd11, SWR = 4'd12;
  logic clk = 0, rst = 1;
  logic ena = 0, exc = 0, flush = 0, aok = 0, dok = 0;
  logic [3:0] sel = LW;
  logic [31:0] addr = 0, rt = 0, rdata_in = 0;
  logic ls_stall, ls_rdata_valid, data_req, data_wr;
  logic [31:0] ls_rdata, data_addr, data_wdata;
  logic [1:0] data_size;
  logic [3:0] data_wstrb;
  int n_tests = 0, n_fail = 0;
  lsu_req_ctrl dut (
    .clk(clk), .rst(rst), .ex_ls_ena(ena), .ex_ls_sel(sel), .ex_ls_addr(addr),
    .ex_rt_data(rt), .ex_has_exception(exc), .flush(flush), .ls_stall(ls_stall),
    .ls_rdata(ls_rdata), .ls_rdata_valid(ls_rdata_valid), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(aok),
    .data_data_ok(dok), .data_rdata(rdata_in)
  );
  always #5 clk = ~clk;
  // transaction model: presented-to-bus, accepted-awaiting-response, cancelled-awaiting-response
  bit m_req, m_acc, m_cxl, m_valid, m_wr;
  logic [31:0] m_rdata, m_addr, m_wdata;
  logic [3:0] m_strb;
  logic [1:0] m_size;
  bit n_req, n_acc, n_cxl, n_valid, n_wr;
  logic [31:0] n_rdata, n_addr, n_wdata;
  logic [3:0] n_strb;
  logic [1:0] n_size;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  task automatic access(input logic [3:0] s, input logic [31:0] ad, input logic [31:0] r,
                        output bit wr, output logic [1:0] sz, output logic [31:0] ba,
                        output logic [3:0] st, output logic [31:0] wd);
    int a = int'(ad[1:0]);
    bit unal = s inside {LWL, LWR, SWL, SWR};
    wr = s inside {SB, SH, SW, SWL, SWR};
    sz = unal || s inside {LW, SW} ? 2'd2 : s inside {LH, LHU, SH} ? 2'd1 : 2'd0;
    ba = unal ? ad - 32'(a) : ad;
    st = 4'd0;
    wd = r;
    case (s)
      SB: begin st[a] = 1'b1; for (int i = 0; i < 4; i++) wd[8*i +: 8] = r[7:0]; end
      SH: begin st = (a == 0) ? 4'b0011 : 4'b1100; wd = {r[15:0], r[15:0]}; end
      SW: st = 4'b1111;
      SWL: begin wd = 0; for (int i = 0; i <= a; i++) begin st[i] = 1'b1; wd[8*i +: 8] = r[8*(3-a+i) +: 8]; end end
      SWR: begin wd = 0; for (int i = a; i < 4; i++) begin st[i] = 1'b1; wd[8*i +: 8] = r[8*(i-a) +: 8]; end end
      default: ;
    endcase
  endtask
  task automatic settle();
    bit idle, start, e_stall, done;
    #3;
    idle = !(m_req || m_acc || m_cxl);
    start = idle && ena && !exc && !flush && !rst;
    e_stall = start || (m_req && !(aok && dok)) || (m_acc && !dok) || (m_cxl && ena);
    chk("ls_stall", 32'(ls_stall), 32'(e_stall));
    chk("data_req", 32'(data_req), 32'(m_req));
    chk("ls_rdata_valid", 32'(ls_rdata_valid), 32'(m_valid));
    chk("ls_rdata", ls_rdata, m_rdata);
    if (m_req) begin
      chk("data_wr", 32'(data_wr), 32'(m_wr));
      chk("data_size", 32'(data_size), 32'(m_size));
      chk("data_addr", data_addr, m_addr);
      chk("data_wstrb", 32'(data_wstrb), 32'(m_strb));
      chk("data_wdata", data_wdata, m_wdata);
    end
    {n_req, n_acc, n_cxl, n_wr, n_rdata, n_addr, n_wdata, n_strb, n_size} =
      {m_req, m_acc, m_cxl, m_wr, m_rdata, m_addr, m_wdata, m_strb, m_size};
    done = 0;
    if (start) begin
      n_req = 1;
      access(sel, addr, rt, n_wr, n_size, n_addr, n_strb, n_wdata);
    end
    if (m_req && aok) begin
      n_req = 0;
      if (dok) done = !flush;
      else if (flush) n_cxl = 1;
      else n_acc = 1;
    end else if (m_req && flush) n_req = 0;
    if (m_acc && dok) begin n_acc = 0; done = 1; end
    else if (m_acc && flush) begin n_acc = 0; n_cxl = 1; end
    if (m_cxl && dok) n_cxl = 0;
    n_valid = done;
    if (done && !m_wr) n_rdata = rdata_in;
    if (rst) {n_req, n_acc, n_cxl, n_valid, n_wr, n_rdata, n_addr, n_wdata, n_strb, n_size} = '0;
  endtask
  task automatic adv();
    @(posedge clk);
    #1;
    {m_req, m_acc, m_cxl, m_valid, m_wr, m_rdata, m_addr, m_wdata, m_strb, m_size} =
      {n_req, n_acc, n_cxl, n_valid, n_wr, n_rdata, n_addr, n_wdata, n_strb, n_size};
  endtask
  task automatic step(); settle(); adv(); endtask
  task automatic issue(input logic [3:0] s, input logic [31:0] ad, input logic [31:0] r);
    ena = 1; sel = s; addr = ad; rt = r; aok = 0; dok = 0; flush = 0; exc = 0;
  endtask
  initial begin
    logic [3:0] codes [12] = '{LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW, SWL, SWR};
    @(posedge clk); #1;
    settle(); adv();
    rst = 0;
    settle();
    chk("reset_zero", {ls_rdata, data_addr} | {data_wdata, 28'd0, data_wstrb}, 64'd0);
    adv();
    // LW with addr_ok in cycle 1 and data_ok in cycle 3
    issue(LW, 32'h8000_1004, 0);
    settle(); chk("lw_c0_stall", 32'(ls_stall), 1); adv();
    aok = 1;
    settle(); chk("lw_c1_req", 32'(data_req), 1); chk("lw_c1_addr", data_addr, 32'h8000_1004); adv();
    aok = 0;
    settle(); chk("lw_c2_stall", 32'(ls_stall), 1); adv();
    dok = 1; rdata_in = 32'hDEAD_BEEF;
    settle(); chk("lw_c3_stall", 32'(ls_stall), 0); adv();
    ena = 0; dok = 0;
    settle(); chk("lw_valid", 32'(ls_rdata_valid), 1); chk("lw_rdata", ls_rdata, 32'hDEAD_BEEF); adv();
    settle(); chk("lw_valid_once", 32'(ls_rdata_valid), 0); adv();
    // SB with single-cycle addr_ok+data_ok
    issue(SB, 32'h1000_0002, 32'h0000_00A5);
    step();
    aok = 1; dok = 1; rdata_in = 32'h5555_5555;
    settle();
    chk("sb_wstrb", 32'(data_wstrb), 32'h4); chk("sb_wdata", data_wdata, 32'hA5A5_A5A5);
    chk("sb_size", 32'(data_size), 0); chk("sb_wr", 32'(data_wr), 1); chk("sb_1cyc_stall", 32'(ls_stall), 0);
    adv();
    ena = 0; aok = 0; dok = 0;
    settle(); chk("sb_no_rdata", ls_rdata, 32'hDEAD_BEEF); chk("sb_valid", 32'(ls_rdata_valid), 1); adv();
    // SWR a=1 and SWL a=2
    issue(SWR, 32'h2000_0101, 32'h1122_3344); step();
    aok = 1; dok = 1;
    settle();
    chk("swr_addr", data_addr, 32'h2000_0100); chk("swr_wstrb", 32'(data_wstrb), 32'hE);
    chk("swr_wdata", data_wdata, 32'h2233_4400);
    adv();
    issue(SWL, 32'h2000_0102, 32'h1122_3344); step();
    aok = 1; dok = 1;
    settle(); chk("swl_wstrb", 32'(data_wstrb), 32'h7); chk("swl_wdata", data_wdata, 32'h0011_2233); adv();
    // flush in WAIT, late response discarded, new LW blocked until idle
    issue(LW, 32'h3000_0000, 0); step();
    aok = 1; step();
    aok = 0; flush = 1; step();
    flush = 0; ena = 1; sel = LW; addr = 32'h3000_0040;
    settle(); chk("cxl_block_stall", 32'(ls_stall), 1); chk("cxl_no_req", 32'(data_req), 0); adv();
    dok = 1; rdata_in = 32'h1234_5678;
    settle(); chk("cxl_resp_stall", 32'(ls_stall), 1); adv();
    dok = 0;
    settle(); chk("cxl_no_valid", 32'(ls_rdata_valid), 0); chk("cxl_rdata_kept", ls_rdata, 32'hDEAD_BEEF);
    chk("cxl_restart", 32'(ls_stall), 1); adv();
    aok = 1; dok = 1; rdata_in = 32'h0BAD_F00D; step();
    ena = 0; aok = 0; dok = 0; step();
    // excepted instruction never requests
    issue(SW, 32'h4000_0000, 32'hFFFF_FFFF); exc = 1;
    for (int i = 0; i < 3; i++) begin
      settle(); chk("exc_req", 32'(data_req), 0); chk("exc_stall", 32'(ls_stall), 0); adv();
    end
    // reset while waiting for a response
    issue(LW, 32'h5000_0008, 0); step();
    aok = 1; step();
    aok = 0; ena = 0; rst = 1; step();
    settle();
    chk("rst_wait_outs", {ls_rdata, data_addr, data_wdata}, 96'd0);
    chk("rst_wait_ctl", {data_req, data_wr, data_size, data_wstrb, ls_stall, ls_rdata_valid}, 0);
    adv();
    rst = 0; dok = 1; rdata_in = 32'hCAFE_CAFE; step();
    dok = 0;
    settle(); chk("rst_stale_dok", {ls_rdata_valid, ls_rdata}, 0); adv();
    // random traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      ena = $urandom_range(0, 1);
      exc = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      sel = codes[$urandom_range(0, 11)];
      addr = $urandom;
      if (sel == SH) addr[0] = 1'b0;
      rt = $urandom;
      rdata_in = $urandom;
      aok = m_req ? $urandom_range(0, 1) : ($urandom_range(0, 15) == 0);
      dok = (m_acc || m_cxl) ? ($urandom_range(0, 2) == 0) :
            (m_req && aok) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 11) == 0);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
